router_vc_fifo: RTL and testbench
=================================

Name: router_vc_fifo

Overview:
Multi-virtual-channel input buffer for the packet-switched router. It holds NumVc independent FIFOs of Depth entries each, with one write port and one read port, each steered by a VC index. It provides optional zero-latency bypass, per-VC occupancy counters and almost-full flags for credit/backpressure generation, and a sticky overflow error. It sits at each router input port, between the link receiver and the route/VC-allocation stage.

Parameters:
BypassEnable, 1, forward data_in to data_out when the addressed VC is empty and read/write target the same VC
NumVc, 2, number of virtual channels (>=1)
Depth, 4, entries per VC (>=2)
Width, 8, data bit-width
AlmostFullThr, 3, almost_full[v] asserted when count[v] >= AlmostFullThr (1..Depth)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
wrreq  in  1  push data_in into VC wr_vc
wr_vc  in  VcW  target VC of write; VcW = max(1, $clog2(NumVc))
data_in  in  Width  write data
rdreq  in  1  pop head of VC rd_vc
rd_vc  in  VcW  VC selected for read and data_out
data_out  out  Width  head of VC rd_vc, or data_in on bypass
empty  out  NumVc  per-VC empty
full  out  NumVc  per-VC full
almost_full  out  NumVc  per-VC count >= AlmostFullThr
count  out  NumVc*$clog2(Depth+1)  per-VC occupancy; VC v occupies slice v
overflow  out  1  sticky: a write hit a full VC; cleared only by rst

Behaviour:
- Reset (async assert, sync-to-clk deassert assumed upstream): all heads/tails=0, count=0, empty=all 1, full=0, almost_full=0, overflow=0, storage cleared to 0.
- Per VC: circular buffer with head/tail pointers in 0..Depth-1; wrap Depth-1 -> 0. Pointers are never shared between VCs.
- wr_vc/rd_vc values >= NumVc: the access is ignored (no state change). overflow is not set.
- Definitions, with e = empty[rd_vc] and same = (wr_vc == rd_vc):
  - bypass = BypassEnable & e & same & wrreq & rdreq.
  - valid_read = rdreq & ~empty[rd_vc].
  - valid_write = wrreq & ~full[wr_vc] & ~bypass.
- On bypass, data_out = data_in in the same cycle. No pointer or count changes.
- data_out = data_in when BypassEnable & e & same. Otherwise data_out = mem[rd_vc][head[rd_vc]], combinational, zero latency. data_out is don't-care when empty without bypass.
- valid_write: store at tail[wr_vc], tail advances, count[wr_vc]+1 (unless same-VC read).
- valid_read: head[rd_vc] advances, count[rd_vc]-1 (unless same-VC write).
- Same VC, both valid: count unchanged, both pointers advance.
- Different VCs: the updates are independent, and both occur in the same cycle.
- Write to a full VC: dropped, no state change, overflow <= 1 on the next edge. This holds even if the same-cycle read on that VC frees a slot; a full-VC write is never accepted.
- Read of an empty VC without bypass: ignored.
- empty/full/almost_full/count are registered-state derived only (combinational from count), never from the current-cycle requests.
- Reset mid-operation: all VCs are discarded immediately on rst assertion.

Test Plan:
- Reset then idle: count=0 all VCs, empty=2'b11, full=0, overflow=0. Assert rst mid-stream with VC0 holding 3 entries -> empty[0]=1 asynchronously.
- NumVc=2, Depth=4: write 0xA1,0xA2 to VC1, 0xB1 to VC0. Then rd_vc=1 with reads -> data_out 0xA1 then 0xA2. VC0 is still 0xB1, count[0]=1.
- Fill VC0 with 4 writes -> full[0]=1, almost_full[0] set at count 3. A 5th write of 0xFF is dropped and overflow=1 (sticky). Drain gives 4 original values in order. Pointers wrap: 6 further write/read pairs keep FIFO order.
- Bypass: VC0 empty, wrreq=rdreq=1, wr_vc=rd_vc=0, data_in=0x5C -> data_out=0x5C same cycle, count[0] stays 0. With BypassEnable=0 the same stimulus stores 0x5C, count[0]=1.
- Simultaneous: VC0 count=2, read VC0 while writing VC1 -> count[0]=1, count[1]=1. Read and write VC0 together -> count[0] unchanged, order preserved.
- Full VC with simultaneous read+write on it -> read accepted, write dropped, count=Depth-1, overflow=1.

Source files
------------

// File: rtl/router_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_vc_fifo
// Purpose  : Multi-virtual-channel input buffer. NumVc independent circular
//            FIFOs of Depth entries, one write and one read port each steered
//            by a VC index. Provides an optional zero-latency bypass,
//            per-VC occupancy, empty/full/almost-full flags for credit
//            generation, and a sticky overflow error.
// Revision : 1.0 - initial release
// ============================================================================
module router_vc_fifo #(
  parameter int BypassEnable  = 1,
  parameter int NumVc         = 2,
  parameter int Depth         = 4,
  parameter int Width         = 8,
  parameter int AlmostFullThr = 3,
  localparam int VcW          = (NumVc > 1) ? $clog2(NumVc) : 1,
  localparam int CntW         = $clog2(Depth + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrreq,
  input  logic [VcW-1:0]          wr_vc,
  input  logic [Width-1:0]        data_in,
  input  logic                    rdreq,
  input  logic [VcW-1:0]          rd_vc,
  output logic [Width-1:0]        data_out,
  output logic [NumVc-1:0]        empty,
  output logic [NumVc-1:0]        full,
  output logic [NumVc-1:0]        almost_full,
  output logic [NumVc*CntW-1:0]   count,
  output logic                    overflow
);

  localparam int  PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic c_byp  = (BypassEnable != 0);

  // Out-of-range VC indices make the corresponding access a no-op.
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_rd_empty;
  logic w_same_vc;
  logic w_bypass_path;
  logic w_bypass;
  logic w_wr_full;

  // Head-of-queue word of every VC, muxed onto data_out by rd_vc.
  logic [Width-1:0] w_head_data [NumVc];

  assign w_wr_ok       = (int'(wr_vc) < NumVc);
  assign w_rd_ok       = (int'(rd_vc) < NumVc);
  assign w_rd_empty    = w_rd_ok & empty[rd_vc];
  assign w_same_vc     = (wr_vc == rd_vc);
  // The output path switches to data_in whenever the read VC is empty and
  // both ports address it, regardless of whether requests are present.
  assign w_bypass_path = c_byp & w_rd_empty & w_same_vc;
  assign w_bypass      = w_bypass_path & wrreq & rdreq;
  assign w_wr_full     = w_wr_ok & full[wr_vc];

  // Read-side mux: bypass data, else the head entry of the selected VC.
  always_comb begin
    data_out = '0;
    if (w_rd_ok) begin
      data_out = w_head_data[rd_vc];
    end
    if (w_bypass_path) begin
      data_out = data_in;
    end
  end

  // Sticky overflow: any write that addresses a full VC, even when a
  // same-cycle read on that VC frees a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wrreq && w_wr_full) begin
      overflow <= 1'b1;
    end
  end

  generate
    for (genvar v = 0; v < NumVc; v++) begin : g_vc
      logic [PtrW-1:0]  r_head;
      logic [PtrW-1:0]  r_tail;
      logic [CntW-1:0]  r_cnt;
      logic [Width-1:0] r_mem [Depth];
      logic             w_do_wr;
      logic             w_do_rd;
      logic [PtrW-1:0]  w_head_nxt;
      logic [PtrW-1:0]  w_tail_nxt;

      // A bypassed write never touches storage; the bypass can only occur
      // on an empty VC, so it never coincides with a valid read here.
      assign w_do_wr = wrreq & w_wr_ok & (wr_vc == VcW'(v)) & ~full[v] & ~w_bypass;
      assign w_do_rd = rdreq & w_rd_ok & (rd_vc == VcW'(v)) & ~empty[v];

      assign w_head_nxt = (r_head == PtrW'(Depth - 1)) ? '0 : r_head + 1'b1;
      assign w_tail_nxt = (r_tail == PtrW'(Depth - 1)) ? '0 : r_tail + 1'b1;

      // Per-VC pointer, occupancy and storage update.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_head <= '0;
          r_tail <= '0;
          r_cnt  <= '0;
          for (int i = 0; i < Depth; i++) begin
            r_mem[i] <= '0;
          end
        end else begin
          if (w_do_wr) begin
            r_mem[r_tail] <= data_in;
            r_tail        <= w_tail_nxt;
          end
          if (w_do_rd) begin
            r_head <= w_head_nxt;
          end
          case ({w_do_wr, w_do_rd})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      // Status flags depend on registered occupancy only.
      assign w_head_data[v]           = r_mem[r_head];
      assign empty[v]                 = (r_cnt == '0);
      assign full[v]                  = (r_cnt == CntW'(Depth));
      assign almost_full[v]           = (r_cnt >= CntW'(AlmostFullThr));
      assign count[v*CntW +: CntW]    = r_cnt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_router_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_vc_fifo
// Purpose  : Self-checking bench for router_vc_fifo. A per-VC queue model
//            records accepted writes and supplies expected read data.
//            A second instance with the bypass disabled covers that mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_vc_fifo;

  logic       clk = 1'b0;
  logic       rst;

  logic       wrreq, wr_vc, rdreq, rd_vc;
  logic [7:0] data_in, data_out;
  logic [1:0] empty, full, almost_full;
  logic [5:0] count;
  logic       overflow;

  logic       wrreq_nb, wr_vc_nb, rdreq_nb, rd_vc_nb;
  logic [7:0] data_in_nb, data_out_nb;
  logic [1:0] empty_nb, full_nb, almost_full_nb;
  logic [5:0] count_nb;
  logic       overflow_nb;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [2][$];
  bit         exp_ovf;

  always #5 clk = ~clk;

  router_vc_fifo #(.BypassEnable(1), .NumVc(2), .Depth(4), .Width(8), .AlmostFullThr(3)) dut (
    .clk(clk), .rst(rst), .wrreq(wrreq), .wr_vc(wr_vc), .data_in(data_in),
    .rdreq(rdreq), .rd_vc(rd_vc), .data_out(data_out), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count), .overflow(overflow)
  );

  router_vc_fifo #(.BypassEnable(0), .NumVc(2), .Depth(4), .Width(8), .AlmostFullThr(3)) dut_nb (
    .clk(clk), .rst(rst), .wrreq(wrreq_nb), .wr_vc(wr_vc_nb), .data_in(data_in_nb),
    .rdreq(rdreq_nb), .rd_vc(rd_vc_nb), .data_out(data_out_nb), .empty(empty_nb),
    .full(full_nb), .almost_full(almost_full_nb), .count(count_nb), .overflow(overflow_nb)
  );

  // Reset both DUTs and the model; returns one ns after a rising edge.
  task automatic apply_reset();
    rst = 1'b1;
    sb[0].delete();
    sb[1].delete();
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock of stimulus on the bypass DUT. Samples data_out before the
  // edge and returns the model's expectation (chk says whether one exists),
  // then updates the model with what the edge should have accepted.
  task automatic xfer(input logic wr, input logic wv, input logic [7:0] din,
                      input logic rd, input logic rv,
                      output logic [7:0] got, output logic [7:0] exp, output bit chk);
    bit e, byp, wfull;
    wrreq = wr; wr_vc = wv; data_in = din; rdreq = rd; rd_vc = rv;
    #1;
    got   = data_out;
    e     = (sb[rv].size() == 0);
    byp   = wr && rd && e && (wv == rv);
    wfull = (sb[wv].size() == 4);
    chk   = 1'b0;
    exp   = '0;
    if (byp) begin
      exp = din; chk = 1'b1;
    end else if (rd && !e) begin
      exp = sb[rv][0]; chk = 1'b1;
    end
    @(posedge clk); #1;
    if (!byp) begin
      if (rd && !e) void'(sb[rv].pop_front());
      if (wr) begin
        if (wfull) exp_ovf = 1'b1;
        else       sb[wv].push_back(din);
      end
    end
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%h exp=%h", count, 6'd0); end
    checks++; if (empty !== 2'b11) begin failures++; $display("FAIL reset_empty got=%b exp=%b", empty, 2'b11); end
    checks++; if (full !== 2'b00) begin failures++; $display("FAIL reset_full got=%b exp=%b", full, 2'b00); end
    checks++; if (almost_full !== 2'b00) begin failures++; $display("FAIL reset_afull got=%b exp=%b", almost_full, 2'b00); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=%b", overflow, 1'b0); end
    checks++; if (empty_nb !== 2'b11) begin failures++; $display("FAIL reset_empty_nb got=%b exp=%b", empty_nb, 2'b11); end
  endtask

  task automatic test_basic();
    logic [7:0] got, exp; bit chk;
    apply_reset();
    xfer(1, 1, 8'hA1, 0, 0, got, exp, chk);
    xfer(1, 1, 8'hA2, 0, 0, got, exp, chk);
    xfer(1, 0, 8'hB1, 0, 0, got, exp, chk);
    checks++; if (count[5:3] !== 3'(sb[1].size())) begin failures++; $display("FAIL basic_count1 got=%0d exp=%0d", count[5:3], sb[1].size()); end
    for (int i = 0; i < 2; i++) begin
      xfer(0, 0, 8'h00, 1, 1, got, exp, chk);
      checks++; if (!chk || got !== exp) begin failures++; $display("FAIL basic_rd_vc1 got=%h exp=%h", got, exp); end
    end
    checks++; if (count[2:0] !== 3'd1) begin failures++; $display("FAIL basic_count0 got=%0d exp=1", count[2:0]); end
    xfer(0, 0, 8'h00, 1, 0, got, exp, chk);
    checks++; if (!chk || got !== 8'hB1) begin failures++; $display("FAIL basic_rd_vc0 got=%h exp=%h", got, 8'hB1); end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] got, exp; bit chk;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      xfer(1, 0, 8'h10 + 8'(i), 0, 0, got, exp, chk);
      checks++; if (almost_full[0] !== (i >= 2)) begin failures++; $display("FAIL fill_afull n=%0d got=%b exp=%b", i+1, almost_full[0], (i >= 2)); end
      checks++; if (full[0] !== (i == 3)) begin failures++; $display("FAIL fill_full n=%0d got=%b exp=%b", i+1, full[0], (i == 3)); end
    end
    xfer(1, 0, 8'hFF, 0, 0, got, exp, chk);
    checks++; if (overflow !== exp_ovf || !exp_ovf) begin failures++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    checks++; if (count[2:0] !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count[2:0]); end
    for (int i = 0; i < 4; i++) begin
      xfer(0, 0, 8'h00, 1, 0, got, exp, chk);
      checks++; if (!chk || got !== exp) begin failures++; $display("FAIL drain_data got=%h exp=%h", got, exp); end
    end
    checks++; if (empty[0] !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL drain_state got=%b/%b exp=1/1", empty[0], overflow); end
    xfer(1, 0, 8'h30, 0, 0, got, exp, chk);
    xfer(1, 0, 8'h31, 0, 0, got, exp, chk);
    for (int i = 0; i < 6; i++) begin
      xfer(1, 0, 8'h40 + 8'(i), 1, 0, got, exp, chk);
      checks++; if (!chk || got !== exp) begin failures++; $display("FAIL wrap_data got=%h exp=%h", got, exp); end
      checks++; if (count[2:0] !== 3'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", count[2:0]); end
    end
    for (int i = 0; i < 2; i++) begin
      xfer(0, 0, 8'h00, 1, 0, got, exp, chk);
      checks++; if (!chk || got !== exp) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, exp; bit chk;
    apply_reset();
    xfer(1, 0, 8'h61, 0, 0, got, exp, chk);
    xfer(1, 0, 8'h62, 0, 0, got, exp, chk);
    xfer(1, 1, 8'h71, 1, 0, got, exp, chk);
    checks++; if (!chk || got !== 8'h61) begin failures++; $display("FAIL simul_data got=%h exp=%h", got, 8'h61); end
    checks++; if (count !== {3'd1, 3'd1}) begin failures++; $display("FAIL simul_count got=%h exp=%h", count, {3'd1, 3'd1}); end
  endtask

  task automatic test_full_rw();
    logic [7:0] got, exp; bit chk;
    apply_reset();
    for (int i = 0; i < 4; i++) xfer(1, 0, 8'h20 + 8'(i), 0, 0, got, exp, chk);
    xfer(1, 0, 8'hEE, 1, 0, got, exp, chk);
    checks++; if (!chk || got !== 8'h20) begin failures++; $display("FAIL fullrw_data got=%h exp=%h", got, 8'h20); end
    checks++; if (count[2:0] !== 3'd3) begin failures++; $display("FAIL fullrw_count got=%0d exp=3", count[2:0]); end
    checks++; if (overflow !== 1'b1 || full[0] !== 1'b0) begin failures++; $display("FAIL fullrw_flags got=%b/%b exp=1/0", overflow, full[0]); end
    for (int i = 0; i < 3; i++) begin
      xfer(0, 0, 8'h00, 1, 0, got, exp, chk);
      checks++; if (!chk || got !== exp) begin failures++; $display("FAIL fullrw_drain got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] got, exp; bit chk;
    apply_reset();
    xfer(1, 0, 8'h5C, 1, 0, got, exp, chk);
    checks++; if (!chk || got !== 8'h5C) begin failures++; $display("FAIL bypass_data got=%h exp=%h", got, 8'h5C); end
    checks++; if (count[2:0] !== 3'd0 || empty[0] !== 1'b1) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count[2:0]); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bypass_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_bypass_off();
    apply_reset();
    wrreq_nb = 1'b1; rdreq_nb = 1'b1; wr_vc_nb = 1'b0; rd_vc_nb = 1'b0; data_in_nb = 8'h5C;
    @(posedge clk); #1;
    wrreq_nb = 1'b0; rdreq_nb = 1'b0;
    checks++; if (count_nb[2:0] !== 3'd1) begin failures++; $display("FAIL nobyp_count got=%0d exp=1", count_nb[2:0]); end
    rdreq_nb = 1'b1;
    #1;
    checks++; if (data_out_nb !== 8'h5C) begin failures++; $display("FAIL nobyp_data got=%h exp=%h", data_out_nb, 8'h5C); end
    @(posedge clk); #1;
    rdreq_nb = 1'b0;
    checks++; if (empty_nb[0] !== 1'b1) begin failures++; $display("FAIL nobyp_empty got=%b exp=1", empty_nb[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp; bit chk;
    apply_reset();
    for (int i = 0; i < 3; i++) xfer(1, 0, 8'h80 + 8'(i), 0, 0, got, exp, chk);
    checks++; if (count[2:0] !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", count[2:0]); end
    #3 rst = 1'b1;
    #1;
    checks++; if (empty[0] !== 1'b1 || count !== 6'd0) begin failures++; $display("FAIL mid_async got=%b/%h exp=1/00", empty[0], count); end
    @(posedge clk); #1;
    rst = 1'b0;
    sb[0].delete(); sb[1].delete(); exp_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wrreq = 0; wr_vc = 0; data_in = 0; rdreq = 0; rd_vc = 0;
    wrreq_nb = 0; wr_vc_nb = 0; data_in_nb = 0; rdreq_nb = 0; rd_vc_nb = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_fill_wrap();
    test_simultaneous();
    test_full_rw();
    test_bypass();
    test_bypass_off();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
